// File: rtl/intr_ctrl.sv
// Interrupt request controller: edge-detects peripheral IRQs, merges them into the CPU IF register
// via IF_load pulses, defers around CPU IF writes. Optional macro INTC_SYNC_EN adds a 2-flop input synchronizer.
module intr_ctrl #(
    parameter logic [15:0] IF_ADDR = 16'hFF0F,
    parameter int unsigned CNT_W   = 8        // must be >= 3 so one cycle's coalesced count fits
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       irq_req,
    input  logic [4:0]       IF_data,
    input  logic [4:0]       IE_data,
    input  logic [15:0]      addr_ext,
    input  logic             mem_we,
    output logic [4:0]       IF_in,
    output logic             IF_load,
    output logic             irq_any,
    output logic [7:0]       irq_vector,
    output logic [CNT_W-1:0] coal_count
);

    // IF_load is a one-cycle strobe with no back-pressure: the CPU must capture IF_in whenever
    // IF_load is high. A CPU write to IF is the only stall; pend_q then holds until a free cycle.

    logic [4:0]       req_s;
    logic [4:0]       req_q;
    logic [4:0]       pend_q;
    logic [4:0]       pend_vis;
    logic [4:0]       rise;
    logic [4:0]       coal_bits;
    logic [2:0]       coal_n;
    logic [CNT_W:0]   coal_sum;
    logic [CNT_W-1:0] coal_q;
    logic [CNT_W-1:0] coal_d;
    logic [4:0]       active;
    logic             cpu_if_wr;

`ifdef INTC_SYNC_EN
    logic [4:0] sync1_q;
    logic [4:0] sync2_q;

    // Reset to all-ones so a source held high through reset is not seen as an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 5'h1F;
            sync2_q <= 5'h1F;
        end else begin
            sync1_q <= irq_req;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = irq_req;
`endif

    function automatic logic [2:0] popcnt5(input logic [4:0] b);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 5; i++) begin
            n = n + 3'(b[i]);
        end
        return n;
    endfunction

    assign rise      = req_s & ~req_q;
    assign cpu_if_wr = mem_we & (addr_ext == IF_ADDR);

    // Hide pending state while in reset so the outputs show their reset values immediately.
    assign pend_vis  = reset ? 5'h00 : pend_q;
    assign IF_load   = (|pend_vis) & ~cpu_if_wr;
    assign IF_in     = IF_data | pend_vis;

    assign coal_bits = rise & (IF_data | pend_q);
    assign coal_n    = popcnt5(coal_bits);
    assign coal_sum  = {1'b0, coal_q} + (CNT_W+1)'(coal_n);
    assign coal_d    = coal_sum[CNT_W] ? {CNT_W{1'b1}} : coal_sum[CNT_W-1:0];
    assign coal_count = reset ? '0 : coal_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            req_q  <= 5'h1F;
            pend_q <= 5'h00;
            coal_q <= '0;
        end else begin
            req_q  <= req_s;
            coal_q <= coal_d;
            // A load flushes what it delivered; edges arriving in that same cycle stay pending.
            if (IF_load) begin
                pend_q <= rise;
            end else begin
                pend_q <= pend_q | rise;
            end
        end
    end

    assign active  = (IF_data | pend_vis) & IE_data;
    assign irq_any = |active;

    // Scan from lowest priority upward so the last hit (lowest index) wins.
    always_comb begin
        irq_vector = 8'h00;
        for (int i = 4; i >= 0; i--) begin
            if (active[i]) begin
                irq_vector = 8'h40 + 8'(i * 8);
            end
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed stimulus, expected IF loads queued with their cycle, monitor compares.
module tb_intr_ctrl;

`ifdef INTC_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clock;
    logic        reset;
    logic [4:0]  irq_req;
    logic [4:0]  IF_data;
    logic [4:0]  IE_data;
    logic [15:0] addr_ext;
    logic        mem_we;
    logic [4:0]  IF_in;
    logic        IF_load;
    logic        irq_any;
    logic [7:0]  irq_vector;
    logic [7:0]  coal_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Each entry: {cycle in which IF_load must be seen, required IF_in}
    logic [36:0] exp_q[$];

    intr_ctrl #(.IF_ADDR(16'hFF0F), .CNT_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .irq_req    (irq_req),
        .IF_data    (IF_data),
        .IE_data    (IE_data),
        .addr_ext   (addr_ext),
        .mem_we     (mem_we),
        .IF_in      (IF_in),
        .IF_load    (IF_load),
        .irq_any    (irq_any),
        .irq_vector (irq_vector),
        .coal_count (coal_count)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d exp_left=%0d", cyc, exp_q.size());
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_load(input logic [4:0] val, input int dly);
        logic [31:0] c;
        c = 32'(cyc + dly);
        exp_q.push_back({c, val});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    // One-cycle pulse on bit 2 with IF bit 2 already set: always coalesces and always loads.
    task automatic pulse_n(input int n);
        for (int i = 0; i < n; i++) begin
            irq_req = 5'b00100;
            push_load(5'b00100, LAT);
            tick();
            irq_req = 5'b00000;
            tick();
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        logic [36:0] e;
        if (IF_load) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_load cyc=%0d act_if_in=%0h exp=none", cyc, IF_in);
            end else begin
                e = exp_q.pop_front();
                if (e !== {32'(cyc), IF_in}) begin
                    errors++;
                    $display("FAIL load cyc=%0d act_if_in=%0h exp_cyc=%0d exp_if_in=%0h",
                             cyc, IF_in, e[36:5], e[4:0]);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0][36:5] <= 32'(cyc)) begin
            checks++;
            errors++;
            e = exp_q.pop_front();
            $display("FAIL missed_load cyc=%0d act_load=0 exp_cyc=%0d exp_if_in=%0h",
                     cyc, e[36:5], e[4:0]);
        end
    end

    // ---------------- stimulus ----------------
    logic [4:0] vec_if [5] = '{5'b10110, 5'b10110, 5'b01000, 5'b10000, 5'b00001};
    logic [4:0] vec_ie [5] = '{5'b10100, 5'b00000, 5'b11111, 5'b10000, 5'b00001};
    logic [7:0] vec_exp[5] = '{8'h50,    8'h00,    8'h58,    8'h60,    8'h40};

    initial begin
        reset    = 1'b1;
        irq_req  = 5'h1F;
        IF_data  = 5'b01010;
        IE_data  = 5'b00000;
        addr_ext = 16'h0000;
        mem_we   = 1'b0;
        tick(3);
        @(negedge clock);
        chk("reset_if_load", 32'(IF_load), 32'd0);
        chk("reset_if_in", 32'(IF_in), 32'h0A);
        chk("reset_coal", 32'(coal_count), 32'd0);

        // Sources held high through reset must not fire after release.
        tick();
        reset = 1'b0;
        tick(6);
        irq_req = 5'b00000;
        IF_data = 5'b00000;
        tick(LAT + 2);

        // Basic merge
        irq_req = 5'b00100;
        push_load(5'b00100, LAT);
        tick();
        irq_req = 5'b00000;
        tick(LAT + 2);

        // Simultaneous edges merge into one load
        IF_data = 5'b00001;
        irq_req = 5'b10010;
        push_load(5'b10011, LAT);
        tick();
        irq_req = 5'b00000;
        tick(LAT + 2);
        IF_data = 5'b00000;

        // Collision: two CPU IF writes defer the load; new IF value is merged
        irq_req = 5'b00001;
        push_load(5'b01001, LAT + 2);
        tick(LAT);
        mem_we   = 1'b1;
        addr_ext = 16'hFF0F;
        IF_data  = 5'b01000;
        tick(2);
        mem_we   = 1'b0;
        addr_ext = 16'h0000;
        tick(2);
        irq_req = 5'b00000;
        IF_data = 5'b00000;
        tick(LAT + 2);

        // A write to a different address must not defer
        irq_req = 5'b00010;
        push_load(5'b00010, LAT);
        tick(LAT);
        mem_we   = 1'b1;
        addr_ext = 16'hFF0E;
        tick();
        mem_we   = 1'b0;
        addr_ext = 16'h0000;
        irq_req  = 5'b00000;
        tick(LAT + 2);

        // Vector / priority table
        for (int i = 0; i < 5; i++) begin
            IF_data = vec_if[i];
            IE_data = vec_ie[i];
            tick();
            @(negedge clock);
            chk("irq_any", 32'(irq_any), 32'(vec_exp[i] != 8'h00));
            chk("irq_vector", 32'(irq_vector), 32'(vec_exp[i]));
        end

        // Pending (not yet loaded) bit also drives the vector
        IF_data = 5'b00000;
        IE_data = 5'b00010;
        tick();
        irq_req = 5'b00010;
        push_load(5'b00010, LAT);
        tick(LAT);
        @(negedge clock);
        chk("pend_vector", 32'(irq_vector), 32'h48);
        tick();
        irq_req = 5'b00000;
        IE_data = 5'b00000;
        tick(LAT + 2);

        // Coalescing: three bits at once, then saturation
        reset = 1'b1;
        tick();
        reset = 1'b0;
        irq_req = 5'b00000;
        tick(LAT + 2);
        IF_data = 5'b00111;
        irq_req = 5'b00111;
        push_load(5'b00111, LAT);
        tick();
        irq_req = 5'b00000;
        tick(LAT + 1);
        @(negedge clock);
        chk("coal_multi", 32'(coal_count), 32'd3);
        tick();
        IF_data = 5'b00100;
        pulse_n(251);
        tick(LAT + 1);
        @(negedge clock);
        chk("coal_254", 32'(coal_count), 32'd254);
        tick();
        pulse_n(1);
        tick(LAT + 1);
        @(negedge clock);
        chk("coal_255", 32'(coal_count), 32'hFF);
        tick();
        pulse_n(45);
        tick(LAT + 1);
        @(negedge clock);
        chk("coal_sat", 32'(coal_count), 32'hFF);
        tick();
        reset = 1'b1;
        @(negedge clock);
        chk("coal_reset", 32'(coal_count), 32'd0);
        chk("reset_if_in2", 32'(IF_in), 32'h04);
        tick();
        reset   = 1'b0;
        IF_data = 5'b00000;
        tick(3);

        // Reset while a request is pending: no load, and the held source stays quiet
        irq_req = 5'b01000;
        tick(LAT);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset_if_load", 32'(IF_load), 32'd0);
        chk("midreset_if_in", 32'(IF_in), 32'd0);
        tick();
        reset = 1'b0;
        tick(LAT + 4);
        irq_req = 5'b00000;
        tick(LAT + 2);

        // Re-arm bit 3 after reset: fires with the configured latency
        irq_req = 5'b01000;
        push_load(5'b01000, LAT);
        tick();
        irq_req = 5'b00000;

        // ---------------- final report ----------------
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick(3);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
